// File: rtl/hpm_pkg.sv
// Shared definitions for the HPM tracer / window-detector pair.
// Counter geometry, detector state encoding and bound-select codes.
package hpm_pkg;

  localparam int HPM_NUM_CNT = 3;
  localparam int HPM_CNT_W   = 32;

  localparam logic CFG_LO = 1'b0;
  localparam logic CFG_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } det_state_e;

endpackage : hpm_pkg

// File: rtl/hpm_bound_regs.sv
// Per-counter lo/hi bound register file with one write port and one indexed read port.
// Reads are combinational, so a compare at a write edge sees the old bound.
module hpm_bound_regs
  import hpm_pkg::*;
#(
  parameter int NUM_CNT = HPM_NUM_CNT,
  parameter int CNT_W   = HPM_CNT_W,
  parameter int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic             clk_h,
  input  logic             rst_h,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_lo,
  output logic [CNT_W-1:0] rd_hi
);

  logic [CNT_W-1:0] lo_r [NUM_CNT];
  logic [CNT_W-1:0] hi_r [NUM_CNT];
  logic [CNT_W-1:0] rd_lo_s;
  logic [CNT_W-1:0] rd_hi_s;

  // Bound storage; out-of-range indices match no entry and are dropped.
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        lo_r[i] <= '0;
        hi_r[i] <= '1;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          if (cfg_sel == CFG_HI) begin
            hi_r[i] <= cfg_data;
          end else begin
            lo_r[i] <= cfg_data;
          end
        end
      end
    end
  end

  // Indexed read mux.
  always_comb begin
    rd_lo_s = '0;
    rd_hi_s = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      rd_lo_s = (rd_idx == IDX_W'(i)) ? lo_r[i] : rd_lo_s;
      rd_hi_s = (rd_idx == IDX_W'(i)) ? hi_r[i] : rd_hi_s;
    end
  end

  assign rd_lo = rd_lo_s;
  assign rd_hi = rd_hi_s;

endmodule : hpm_bound_regs

// File: rtl/hpm_window_detector.sv
// Checks an HPM counter snapshot against per-counter bounds, one counter per cycle,
// pulses EndDetect back to the tracer and raises a sticky alarm on repeated anomalies.
module hpm_window_detector
  import hpm_pkg::*;
#(
  parameter int NUM_CNT     = HPM_NUM_CNT,
  parameter int CNT_W       = HPM_CNT_W,
  parameter int ALARM_LIMIT = 2,
  parameter int IDX_W       = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic                            clk_h,
  input  logic                            rst_h,
  input  logic                            EnableDetect,
  input  logic [NUM_CNT-1:0][CNT_W-1:0]   HPMout,
  input  logic                            cfg_we,
  input  logic [IDX_W-1:0]                cfg_idx,
  input  logic                            cfg_sel,
  input  logic [CNT_W-1:0]                cfg_data,
  input  logic                            clear_attack,
  output logic                            EndDetect,
  output logic [NUM_CNT-1:0]              anomaly_mask,
  output logic                            attack,
  output logic                            busy
);

  localparam int CONS_W = $clog2(ALARM_LIMIT + 1);

  det_state_e                    state_r;
  det_state_e                    state_s;
  logic [NUM_CNT-1:0][CNT_W-1:0] snap_r;
  logic [IDX_W-1:0]              idx_r;
  logic [NUM_CNT-1:0]            mask_r;
  logic [NUM_CNT-1:0]            anomaly_mask_r;
  logic [CONS_W-1:0]             consec_r;
  logic [CONS_W-1:0]             consec_inc_s;
  logic [CONS_W-1:0]             consec_next_s;
  logic                          attack_r;
  logic                          attack_next_s;
  logic                          end_detect_r;
  logic                          busy_r;
  logic [CNT_W-1:0]              snap_sel_s;
  logic [CNT_W-1:0]              lo_s;
  logic [CNT_W-1:0]              hi_s;
  logic                          flag_s;

  hpm_bound_regs #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_bounds (
    .clk_h    (clk_h),
    .rst_h    (rst_h),
    .cfg_we   (cfg_we),
    .cfg_idx  (cfg_idx),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .rd_idx   (idx_r),
    .rd_lo    (lo_s),
    .rd_hi    (hi_s)
  );

  // Select the snapshot entry under test and compare it against its bounds.
  always_comb begin
    snap_sel_s = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      snap_sel_s = (idx_r == IDX_W'(i)) ? snap_r[i] : snap_sel_s;
    end
    flag_s = (snap_sel_s < lo_s) || (snap_sel_s > hi_s);
  end

  // Next-state logic for the IDLE -> CHECK -> REPORT walk.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (EnableDetect) begin
          state_s = CHECK;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (idx_r == IDX_W'(NUM_CNT - 1)) begin
          state_s = REPORT;
        end else begin
          state_s = CHECK;
        end
      end
      REPORT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Consecutive-window counter and alarm update; clear_attack overrides the report.
  always_comb begin
    consec_inc_s  = (consec_r == CONS_W'(ALARM_LIMIT)) ? consec_r : consec_r + CONS_W'(1);
    consec_next_s = consec_r;
    attack_next_s = attack_r;
    if (clear_attack) begin
      consec_next_s = '0;
      attack_next_s = 1'b0;
    end else if (state_r == REPORT) begin
      if (mask_r != '0) begin
        consec_next_s = consec_inc_s;
        attack_next_s = attack_r | (consec_inc_s == CONS_W'(ALARM_LIMIT));
      end else begin
        consec_next_s = '0;
        attack_next_s = attack_r;
      end
    end else begin
      consec_next_s = consec_r;
      attack_next_s = attack_r;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      state_r        <= IDLE;
      snap_r         <= '0;
      idx_r          <= '0;
      mask_r         <= '0;
      anomaly_mask_r <= '0;
      consec_r       <= '0;
      attack_r       <= 1'b0;
      end_detect_r   <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r      <= state_s;
      end_detect_r <= (state_s == REPORT);
      busy_r       <= (state_s != IDLE);
      consec_r     <= consec_next_s;
      attack_r     <= attack_next_s;
      case (state_r)
        IDLE: begin
          if (EnableDetect) begin
            snap_r <= HPMout;
            mask_r <= '0;
            idx_r  <= '0;
          end
        end
        CHECK: begin
          for (int i = 0; i < NUM_CNT; i++) begin
            if (idx_r == IDX_W'(i)) begin
              mask_r[i] <= flag_s;
            end
          end
          idx_r <= idx_r + IDX_W'(1);
        end
        REPORT: begin
          anomaly_mask_r <= mask_r;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign EndDetect    = end_detect_r;
  assign anomaly_mask = anomaly_mask_r;
  assign attack       = attack_r;
  assign busy         = busy_r;

endmodule : hpm_window_detector

// File: tb/tb_hpm_window_detector.sv
// Directed bench for hpm_window_detector: table of windows plus hand-built corner sequences.
module tb_hpm_window_detector;

  logic                 clk_h = 1'b0;
  logic                 rst_h;
  logic                 EnableDetect;
  logic [2:0][31:0]     HPMout;
  logic                 cfg_we;
  logic [1:0]           cfg_idx;
  logic                 cfg_sel;
  logic [31:0]          cfg_data;
  logic                 clear_attack;
  logic                 EndDetect;
  logic [2:0]           anomaly_mask;
  logic                 attack;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  hpm_window_detector #(.NUM_CNT(3), .CNT_W(32), .ALARM_LIMIT(2)) dut (
    .clk_h        (clk_h),
    .rst_h        (rst_h),
    .EnableDetect (EnableDetect),
    .HPMout       (HPMout),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .clear_attack (clear_attack),
    .EndDetect    (EndDetect),
    .anomaly_mask (anomaly_mask),
    .attack       (attack),
    .busy         (busy)
  );

  always #5 clk_h = ~clk_h;

  typedef struct {
    logic [31:0] h1;
    bit          clr;
    logic [2:0]  mask;
    logic        att;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // One window: sample edge 0, then 8 observed edges with optional side stimulus.
  task automatic run_win(input string nm, input logic [31:0] h0, input logic [31:0] h1,
                         input logic [31:0] h2, input bit clr, input bit en2, input bit wr,
                         input bit rst, input int exp_edge);
    int cnt;
    int at;
    HPMout[0] = h0; HPMout[1] = h1; HPMout[2] = h2;
    EnableDetect = 1'b1;
    tick();
    EnableDetect = 1'b0;
    HPMout[0] = ~h0; HPMout[1] = ~h1; HPMout[2] = ~h2;
    cnt = 0;
    at  = 0;
    for (int k = 1; k <= 8; k++) begin
      clear_attack = clr && (k == 4);
      EnableDetect = en2 && (k == 1);
      rst_h        = rst && (k == 2);
      if (wr && (k == 3)) begin
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_sel = 1'b1; cfg_data = 32'd0;
      end else begin
        cfg_we = 1'b0;
      end
      tick();
      if (k == 1) chk({nm, " busy"}, {31'd0, busy}, 32'd1);
      if (rst && (k == 2)) chk({nm, " busy_after_rst"}, {31'd0, busy}, 32'd0);
      if (EndDetect) begin
        cnt++;
        at = k;
      end
    end
    clear_attack = 1'b0; EnableDetect = 1'b0; rst_h = 1'b0; cfg_we = 1'b0;
    chk({nm, " pulses"}, cnt, (exp_edge == 0) ? 32'd0 : 32'd1);
    if (exp_edge != 0) chk({nm, " pulse_edge"}, at, exp_edge);
  endtask

  initial begin
    tbl[0] = '{h1: 32'd51,  clr: 1'b0, mask: 3'b010, att: 1'b0};
    tbl[1] = '{h1: 32'd50,  clr: 1'b0, mask: 3'b000, att: 1'b0};
    tbl[2] = '{h1: 32'd10,  clr: 1'b0, mask: 3'b000, att: 1'b0};
    tbl[3] = '{h1: 32'd9,   clr: 1'b0, mask: 3'b010, att: 1'b0};
    tbl[4] = '{h1: 32'd60,  clr: 1'b0, mask: 3'b010, att: 1'b1};
    tbl[5] = '{h1: 32'd0,   clr: 1'b1, mask: 3'b010, att: 1'b0};
    tbl[6] = '{h1: 32'd51,  clr: 1'b0, mask: 3'b010, att: 1'b0};
    tbl[7] = '{h1: 32'd100, clr: 1'b0, mask: 3'b010, att: 1'b1};
    tbl[8] = '{h1: 32'd20,  clr: 1'b0, mask: 3'b000, att: 1'b1};

    rst_h = 1'b1; EnableDetect = 1'b0; HPMout = '0; cfg_we = 1'b0;
    cfg_idx = 2'd0; cfg_sel = 1'b0; cfg_data = 32'd0; clear_attack = 1'b0;
    tick();
    tick();
    rst_h = 1'b0;
    chk("reset EndDetect", {31'd0, EndDetect}, 32'd0);
    chk("reset mask", {29'd0, anomaly_mask}, 32'd0);
    chk("reset attack", {31'd0, attack}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);

    run_win("default", 32'd5, 32'd100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("default mask", {29'd0, anomaly_mask}, 32'd0);
    chk("default attack", {31'd0, attack}, 32'd0);

    cfg_write(2'd1, 1'b0, 32'd10);
    cfg_write(2'd1, 1'b1, 32'd50);
    cfg_write(2'd3, 1'b0, 32'hFFFF_FFFF);

    for (int v = 0; v < 9; v++) begin
      run_win($sformatf("vec%0d", v), 32'd5, tbl[v].h1, 32'd7, tbl[v].clr, 1'b0, 1'b0, 1'b0, 3);
      chk($sformatf("vec%0d mask", v), {29'd0, anomaly_mask}, {29'd0, tbl[v].mask});
      chk($sformatf("vec%0d attack", v), {31'd0, attack}, {31'd0, tbl[v].att});
    end

    clear_attack = 1'b1;
    tick();
    clear_attack = 1'b0;
    chk("idle clear attack", {31'd0, attack}, 32'd0);

    cfg_write(2'd0, 1'b0, 32'd20);
    cfg_write(2'd0, 1'b1, 32'd10);
    run_win("lo_gt_hi", 32'd15, 32'd20, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("lo_gt_hi mask", {29'd0, anomaly_mask}, 32'd1);
    cfg_write(2'd0, 1'b0, 32'd0);
    cfg_write(2'd0, 1'b1, 32'hFFFF_FFFF);

    run_win("overlap", 32'd5, 32'd20, 32'd7, 1'b0, 1'b1, 1'b1, 1'b0, 3);
    chk("overlap mask", {29'd0, anomaly_mask}, 32'd0);
    run_win("new_hi2", 32'd5, 32'd20, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("new_hi2 mask", {29'd0, anomaly_mask}, 32'd4);
    chk("new_hi2 attack", {31'd0, attack}, 32'd0);

    run_win("midrst", 32'd5, 32'd20, 32'd7, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("midrst mask", {29'd0, anomaly_mask}, 32'd0);
    run_win("post_rst", 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("post_rst mask", {29'd0, anomaly_mask}, 32'd0);
    chk("post_rst attack", {31'd0, attack}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hpm_window_detector
